vnu_serial_acc: RTL and testbench

Serial variable-node accumulator for the LDPC VNU datapath; sits directly downstream of the sign-magnitude-to-two's-complement converter. It accepts the DV check-to-variable messages of one variable node, one per cycle in two's complement, and adds them to the channel LLR. It then emits DV extrinsic variable-to-check messages (total minus own message), each saturated to the symmetric sign-magnitude-representable range, ready for the two's-complement-to-sign-magnitude stage.

---
 rtl/vnu_pkg.sv | 25 ++
 rtl/vnu_sat.sv | 25 ++
 rtl/vnu_serial_acc.sv | 107 ++++++++++
 tb/tb_vnu_serial_acc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vnu_pkg.sv
// Shared VNU types and sizing helpers: default message width, FSM states,
// internal sum width and the symmetric sign-magnitude limits.
package vnu_pkg;

  localparam int VNU_DATA_WIDTH = 6;

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } vnu_state_t;

  // Enough headroom for llr + dv messages and the signed subtraction after it
  function automatic int vnu_sum_w(input int dw, input int dv);
    return dw + $clog2(dv + 1) + 1;
  endfunction

  // -2^(dw-1) has no sign-magnitude encoding, so the range is symmetric
  function automatic int vnu_sym_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  localparam int VNU_SYM_MAX = (1 << (VNU_DATA_WIDTH - 1)) - 1;
  localparam int VNU_SYM_MIN = -VNU_SYM_MAX;

endpackage

// File: rtl/vnu_sat.sv
// Combinational symmetric saturator: wide signed value to OUT_W bits, clamped to +/-(2^(OUT_W-1)-1).
// Zero latency, no flow control.
module vnu_sat
  import vnu_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = VNU_DATA_WIDTH
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(vnu_sym_max(OUT_W));
  localparam logic signed [IN_W-1:0] LO = -HI;

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > HI) begin
      dout = HI[OUT_W-1:0];
    end else if (din < LO) begin
      dout = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/vnu_serial_acc.sv
// Serial VNU accumulator: DV messages in, then DV saturated extrinsic messages out (2*DV cycles/node).
// Full valid/ready on both sides, never both at once; VNU_HARD_DEC_EN adds the hard_bit output.
module vnu_serial_acc
  import vnu_pkg::*;
#(
  parameter int DATA_WIDTH = VNU_DATA_WIDTH,
  parameter int DV         = 3,
  localparam int IDX_W     = ($clog2(DV) > 1) ? $clog2(DV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] llr_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_msg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_msg,
  output logic [IDX_W-1:0]      out_idx
`ifdef VNU_HARD_DEC_EN
  ,
  output logic                  hard_bit
`endif
);

  localparam int SUM_W = vnu_sum_w(DATA_WIDTH, DV);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DV - 1);

  vnu_state_t state_q, state_d;
  logic [IDX_W-1:0]              cnt_q;
  logic [IDX_W-1:0]              k_q;
  logic signed [SUM_W-1:0]       sum_q;
  logic signed [SUM_W-1:0]       sum_d;
  logic signed [SUM_W-1:0]       ext_d;
  logic signed [DATA_WIDTH-1:0]  msg_buf [DV];
  logic                          in_acc;
  logic                          out_hs;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && cnt_q == LAST) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && k_q == LAST) state_d = ACC;
      end
    endcase
  end

  assign in_acc = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // llr_in only matters on the first message of a node
  assign sum_d = (cnt_q == '0 ? SUM_W'($signed(llr_in)) : sum_q) + SUM_W'($signed(in_msg));
  assign ext_d = sum_q - SUM_W'(msg_buf[k_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      for (int i = 0; i < DV; i++) msg_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      if (in_acc) begin
        sum_q          <= sum_d;
        msg_buf[cnt_q] <= $signed(in_msg);
        cnt_q          <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      if (out_hs) begin
        k_q <= (k_q == LAST) ? '0 : k_q + 1'b1;
      end
    end
  end

  vnu_sat #(
    .IN_W (SUM_W),
    .OUT_W(DATA_WIDTH)
  ) u_sat (
    .din (ext_d),
    .dout(out_msg)
  );

  assign out_idx = k_q;

`ifdef VNU_HARD_DEC_EN
  // Captured with the final sum so it holds steady outside EMIT
  logic hard_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hard_q <= 1'b0;
    end else if (in_acc && cnt_q == LAST) begin
      hard_q <= sum_d[SUM_W-1];
    end
  end

  assign hard_bit = hard_q;
`endif

endmodule

// File: tb/tb_vnu_serial_acc.sv
// Bench for vnu_serial_acc: directed cases plus randomized nodes against an arithmetic reference.
module tb_vnu_serial_acc;

  localparam int DW = 6;
  localparam int DV = 3;
  localparam int IW = 2;
  localparam int LIM = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] llr_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_msg;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_msg;
  logic [IW-1:0] out_idx;
`ifdef VNU_HARD_DEC_EN
  logic          hard_bit;
`endif

  int total = 0;
  int bad   = 0;
  int node_llr;
  int node_msg [DV];
  int exp_msg  [DV];
  int exp_hard;

  always #5 clk = ~clk;

  vnu_serial_acc #(
    .DATA_WIDTH(DW),
    .DV        (DV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .llr_in   (llr_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_msg   (in_msg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_msg  (out_msg),
    .out_idx  (out_idx)
`ifdef VNU_HARD_DEC_EN
    ,
    .hard_bit (hard_bit)
`endif
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: total = llr + all messages; each output = clamp(total - own message)
  function automatic void model();
    int s;
    int e;
    s = node_llr;
    for (int i = 0; i < DV; i++) s += node_msg[i];
    for (int k = 0; k < DV; k++) begin
      e = s - node_msg[k];
      exp_msg[k] = (e > LIM) ? LIM : ((e < -LIM) ? -LIM : e);
    end
    exp_hard = (s < 0) ? 1 : 0;
  endfunction

  task automatic send_node(input int n_in, input bit rnd);
    int i;
    int cyc;
    bit acc;
    i = 0;
    cyc = 0;
    while (i < n_in && cyc < 100) begin
      @(negedge clk);
      cyc++;
      chk("ovld_in_acc", 32'(out_valid), 0);
      in_valid = !rnd || ($urandom_range(0, 2) != 0);
      in_msg   = DW'(node_msg[i]);
      llr_in   = (i == 0) ? DW'(node_llr) : DW'($urandom);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
    end
    if (i < n_in) chk("send_timeout", i, n_in);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_node(input int stall_at, input bit rnd);
    int j;
    int cyc;
    int st;
    bit hs;
    j = 0;
    cyc = 0;
    st = 0;
    while (j < DV && cyc < 200) begin
      cyc++;
      chk("out_valid", 32'(out_valid), 1);
      chk("in_ready_emit", 32'(in_ready), 0);
      chk("out_idx", 32'(out_idx), j);
      chk("out_msg", 32'($signed(out_msg)), exp_msg[j]);
`ifdef VNU_HARD_DEC_EN
      chk("hard_bit", 32'(hard_bit), exp_hard);
`endif
      if (j == stall_at && st < 3) begin
        out_ready = 1'b0;
        st++;
      end else begin
        out_ready = !rnd || ($urandom_range(0, 2) != 0);
      end
      in_valid = 1'($urandom_range(0, 1));
      in_msg   = DW'($urandom);
      llr_in   = DW'($urandom);
      hs = out_valid && out_ready;
      @(posedge clk);
      if (hs) j++;
      @(negedge clk);
    end
    if (j < DV) chk("recv_timeout", j, DV);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("in_ready_back", 32'(in_ready), 1);
    chk("ovld_fall", 32'(out_valid), 0);
  endtask

  task automatic run_node(input int llr, input int m0, input int m1, input int m2,
                          input int stall_at, input bit rnd);
    node_llr    = llr;
    node_msg[0] = m0;
    node_msg[1] = m1;
    node_msg[2] = m2;
    model();
    send_node(DV, rnd);
    recv_node(stall_at, rnd);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_msg"}, 32'($signed(out_msg)), 0);
    chk({tag, "_out_idx"}, 32'(out_idx), 0);
`ifdef VNU_HARD_DEC_EN
    chk({tag, "_hard_bit"}, 32'(hard_bit), 0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_msg    = '0;
    llr_in    = '0;
    out_ready = 1'b1;
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_node(5, 3, -2, 7, -1, 1'b0);
    run_node(31, 31, 31, 31, -1, 1'b0);
    run_node(-31, -31, -31, -31, -1, 1'b0);
    run_node(5, 3, -2, 7, 1, 1'b0);

    // Reset while outputs are pending
    node_llr = -20; node_msg[0] = -5; node_msg[1] = -6; node_msg[2] = 9;
    model();
    send_node(DV, 1'b0);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_emit");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // Reset after a partial node; its messages must be forgotten
    node_llr = 9; node_msg[0] = 4; node_msg[1] = 12; node_msg[2] = 0;
    send_node(2, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_acc");
    @(negedge clk);
    rst = 1'b0;
    run_node(0, 1, 1, 1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_node($urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32,
               $urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32,
               $urandom_range(0, 3) - 1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
